// File: rtl/sa_cache_fsm_pkg.sv
// Shared definitions for the set-associative cache controller: FSM state type
// and address-field width helpers.
package cache_def;

  typedef enum logic [1:0] {
    StIdle,
    StCompare,
    StWriteBack,
    StAllocate
  } sa_state_t;

  // Byte-offset bits within a line (word select plus the two byte bits).
  function automatic int unsigned off_width(input int unsigned words);
    return $clog2(words) + 2;
  endfunction

  function automatic int unsigned idx_width(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_width(input int unsigned sets, input int unsigned words);
    return 32 - off_width(words) - idx_width(sets);
  endfunction

  // Width of a way number; a direct-mapped build still needs one bit.
  function automatic int unsigned way_width(input int unsigned ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/sa_cache_fsm_if.sv
// CPU request/response and line-wide memory bus seen by the cache controller.
interface sa_cache_fsm_if #(
  parameter int unsigned WORDS = 8
);
  localparam int unsigned LINE_BITS = 32 * WORDS;

  logic                 cpu_req_valid;
  logic                 cpu_req_rw;
  logic [31:0]          cpu_req_addr;
  logic [31:0]          cpu_req_data;
  logic                 cpu_res_ready;
  logic [31:0]          cpu_res_data;
  logic                 mem_req_valid;
  logic                 mem_req_rw;
  logic [31:0]          mem_req_addr;
  logic [LINE_BITS-1:0] mem_req_data;
  logic                 mem_ready;
  logic [LINE_BITS-1:0] mem_rdata;

  // Environment side: CPU issuing requests and memory answering them.
  modport master (
    output cpu_req_valid, cpu_req_rw, cpu_req_addr, cpu_req_data,
    input  cpu_res_ready, cpu_res_data,
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data,
    output mem_ready, mem_rdata
  );

  // Cache controller side.
  modport slave (
    input  cpu_req_valid, cpu_req_rw, cpu_req_addr, cpu_req_data,
    output cpu_res_ready, cpu_res_data,
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data,
    input  mem_ready, mem_rdata
  );

endinterface

// File: rtl/sa_cache_fsm_way.sv
// One cache way: tag and line arrays with combinational read, plus per-set
// valid/dirty bits. Fills replace the whole line; CPU write hits replace one word.
module sa_cache_way
  import cache_def::*;
#(
  parameter int unsigned SETS  = 256,
  parameter int unsigned WORDS = 8,
  localparam int unsigned IDX_W     = idx_width(SETS),
  localparam int unsigned TAG_W     = tag_width(SETS, WORDS),
  localparam int unsigned WSEL_W    = $clog2(WORDS),
  localparam int unsigned LINE_BITS = 32 * WORDS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IDX_W-1:0]     idx,
  input  logic                 word_we,
  input  logic [WSEL_W-1:0]    word_sel,
  input  logic [31:0]          word_data,
  input  logic                 fill_we,
  input  logic [TAG_W-1:0]     fill_tag,
  input  logic [LINE_BITS-1:0] fill_line,
  output logic [TAG_W-1:0]     rd_tag,
  output logic [LINE_BITS-1:0] rd_line,
  output logic                 rd_valid,
  output logic                 rd_dirty
);

  logic [TAG_W-1:0]       tag_mem  [SETS];
  logic [WORDS-1:0][31:0] line_mem [SETS];
  logic [SETS-1:0]        valid_q;
  logic [SETS-1:0]        dirty_q;

  // Tag/line storage writes; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_mem[idx]  <= fill_tag;
      line_mem[idx] <= fill_line;
    end else if (word_we) begin
      line_mem[idx][word_sel] <= word_data;
    end
  end

  // Valid/dirty state: a fill leaves the line clean, a write hit dirties it.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_we) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (word_we) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  assign rd_tag   = tag_mem[idx];
  assign rd_line  = line_mem[idx];
  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];

endmodule

// File: rtl/sa_cache_fsm.sv
// Set-associative write-back, write-allocate cache controller: FSM, hit
// detection, victim selection with per-set round-robin, and the way array.
module sa_cache_fsm
  import cache_def::*;
#(
  parameter int unsigned WAYS  = 2,
  parameter int unsigned SETS  = 256,
  parameter int unsigned WORDS = 8
) (
  input logic          clk,
  input logic          rst,
  sa_cache_fsm_if.slave bus
);

  localparam int unsigned OFF_W     = off_width(WORDS);
  localparam int unsigned IDX_W     = idx_width(SETS);
  localparam int unsigned TAG_W     = tag_width(SETS, WORDS);
  localparam int unsigned WSEL_W    = $clog2(WORDS);
  localparam int unsigned PTR_W     = way_width(WAYS);
  localparam int unsigned LINE_BITS = 32 * WORDS;

  sa_state_t        state_q;
  logic [PTR_W-1:0] victim_q;
  logic             all_valid_q;  // set was full at the miss, so rr_ptr advances
  logic [PTR_W-1:0] rr_ptr_q [SETS];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  cpu_tag;
  logic [WSEL_W-1:0] word_sel;
  logic              unused_addr;

  assign idx         = bus.cpu_req_addr[OFF_W +: IDX_W];
  assign cpu_tag     = bus.cpu_req_addr[31 -: TAG_W];
  assign word_sel    = bus.cpu_req_addr[2 +: WSEL_W];
  assign unused_addr = ^bus.cpu_req_addr[1:0];

  logic [WAYS-1:0]      hit_vec;
  logic [WAYS-1:0]      way_valid;
  logic [WAYS-1:0]      way_dirty;
  logic [WAYS-1:0]      word_we;
  logic [WAYS-1:0]      fill_we;
  logic [TAG_W-1:0]     way_tag  [WAYS];
  logic [LINE_BITS-1:0] way_line [WAYS];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign hit_vec[w] = way_valid[w] && (way_tag[w] == cpu_tag);
    assign word_we[w] = (state_q == StCompare) && hit_vec[w] && bus.cpu_req_rw;
    assign fill_we[w] = (state_q == StAllocate) && bus.mem_ready && (victim_q == PTR_W'(w));

    sa_cache_way #(
      .SETS  (SETS),
      .WORDS (WORDS)
    ) u_way (
      .clk       (clk),
      .rst       (rst),
      .idx       (idx),
      .word_we   (word_we[w]),
      .word_sel  (word_sel),
      .word_data (bus.cpu_req_data),
      .fill_we   (fill_we[w]),
      .fill_tag  (cpu_tag),
      .fill_line (bus.mem_rdata),
      .rd_tag    (way_tag[w]),
      .rd_line   (way_line[w]),
      .rd_valid  (way_valid[w]),
      .rd_dirty  (way_dirty[w])
    );
  end

  logic                   hit;
  logic [WORDS-1:0][31:0] hit_line;

  // Hit detection; at most one way can match, so the mux needs no priority.
  always_comb begin
    hit      = 1'b0;
    hit_line = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (hit_vec[w]) begin
        hit      = 1'b1;
        hit_line = way_line[w];
      end
    end
  end

  logic                 all_valid;
  logic                 inv_found;
  logic [PTR_W-1:0]     miss_victim;
  logic                 miss_dirty;
  logic [TAG_W-1:0]     sel_tag;
  logic [LINE_BITS-1:0] sel_line;
  logic [PTR_W-1:0]     rr_next;

  // Victim choice at a miss (lowest invalid way, else rr_ptr) and latched-victim reads.
  always_comb begin
    all_valid   = &way_valid;
    inv_found   = 1'b0;
    miss_victim = rr_ptr_q[idx];
    for (int w = 0; w < WAYS; w++) begin
      if (!inv_found && !way_valid[w]) begin
        miss_victim = PTR_W'(w);
        inv_found   = 1'b1;
      end
    end
    miss_dirty = 1'b0;
    sel_tag    = '0;
    sel_line   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (miss_victim == PTR_W'(w)) miss_dirty = way_dirty[w];
      if (victim_q == PTR_W'(w)) begin
        sel_tag  = way_tag[w];
        sel_line = way_line[w];
      end
    end
    rr_next = (rr_ptr_q[idx] == PTR_W'(WAYS - 1)) ? '0 : rr_ptr_q[idx] + PTR_W'(1);
  end

  // Controller FSM with victim latch and round-robin pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      victim_q    <= '0;
      all_valid_q <= 1'b0;
      for (int s = 0; s < SETS; s++) rr_ptr_q[s] <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.cpu_req_valid) state_q <= StCompare;
        end
        StCompare: begin
          if (hit) begin
            state_q <= StIdle;
          end else begin
            victim_q    <= miss_victim;
            all_valid_q <= all_valid;
            state_q     <= miss_dirty ? StWriteBack : StAllocate;
          end
        end
        StWriteBack: begin
          if (bus.mem_ready) state_q <= StAllocate;
        end
        StAllocate: begin
          if (bus.mem_ready) begin
            state_q <= StCompare;
            if (all_valid_q) rr_ptr_q[idx] <= rr_next;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Bus outputs decoded from the registered state and storage reads.
  always_comb begin
    bus.cpu_res_ready = 1'b0;
    bus.cpu_res_data  = hit_line[word_sel];
    bus.mem_req_valid = 1'b0;
    bus.mem_req_rw    = 1'b0;
    bus.mem_req_addr  = {cpu_tag, idx, {OFF_W{1'b0}}};
    bus.mem_req_data  = sel_line;
    unique case (state_q)
      StCompare: bus.cpu_res_ready = hit;
      StWriteBack: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_rw    = 1'b1;
        bus.mem_req_addr  = {sel_tag, idx, {OFF_W{1'b0}}};
      end
      StAllocate: bus.mem_req_valid = 1'b1;
      default: ;
    endcase
  end

endmodule
